osc_capture_ctrl: RTL and testbench
===================================

Name: osc_capture_ctrl

Overview:
- Sequences oscilloscope acquisition from the 8-bit AD input into an external dual-port frame RAM (write port driven here).
- Provides edge trigger with level, half-buffer pre-trigger, horizontal decimation, auto-trigger timeout, and a frame_ready/frame_ack handshake to the HDMI waveform renderer.
- Sits between the ad_data_in path and the display/FFT readers; enabled by the top-level OSC-menu confirm flag.

Parameters:
ADDR_W, 10, frame RAM address width; DEPTH = 2**ADDR_W samples per frame
AUTO_TO, 4096, decimated samples waited in ARMED before a forced trigger (must be >= 1)

Ports:
clk  in  1  system clock (50 MHz)
rst  in  1  synchronous reset, active-high
run  in  1  acquisition enable (level)
hzoom  in  2  decimation select: 0 = /1, 1 = /2, 2 = /4, 3 = treated as /4
trig_level  in  8  unsigned trigger threshold
trig_edge  in  1  0 = rising, 1 = falling
ad_data  in  8  unsigned ADC sample
ad_valid  in  1  one-cycle sample strobe
wr_en  out  1  frame RAM write enable
wr_addr  out  ADDR_W  frame RAM write address
wr_data  out  8  frame RAM write data
frame_ready  out  1  complete frame held in RAM
frame_ack  in  1  reader done with frame (one-cycle pulse)
start_addr  out  ADDR_W  address of oldest sample of the held frame
auto_trig  out  1  held frame was force-triggered
busy  out  1  high in PRE, ARMED, POST

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high on rst.
- Reset values: state IDLE; wr_en, frame_ready, auto_trig and busy 0; wr_addr, wr_data and start_addr 0.
- Decimation: a sample is accepted when ad_valid = 1 and the decimation counter = 0. The counter runs modulo 1/2/4 on each ad_valid and clears on every entry to PRE.
- Write path: an accepted sample is registered. The next cycle drives wr_en = 1 with wr_data = sample and wr_addr = current address, then the address increments modulo DEPTH (wraps DEPTH-1 -> 0). Write latency is 1 cycle; wr_en is never high in IDLE or HOLD.
- IDLE: wr_addr is held at 0. run = 1 -> PRE.
- PRE: writes accepted samples with no trigger check. After DEPTH/2 writes -> ARMED.
- ARMED: writes continuously as a circular buffer and keeps the previous accepted sample prev. The first ARMED sample uses the last PRE sample as prev.
  - Rising trigger: prev < trig_level and cur >= trig_level.
  - Falling trigger: prev > trig_level and cur <= trig_level.
  - On trigger: the trigger sample is written, start_addr = (its address - DEPTH/2) mod DEPTH, auto_trig = 0, state -> POST.
  - Auto-trigger: if AUTO_TO accepted samples pass without a trigger, the AUTO_TO-th sample is the trigger sample and auto_trig = 1.
  - The timeout counter clears on entry to ARMED.
- POST: writes DEPTH/2-1 further accepted samples; the last write -> HOLD. The frame then holds exactly DEPTH/2 pre-trigger samples and DEPTH/2 samples from the trigger on.
- HOLD: frame_ready = 1, no writes, start_addr and auto_trig stable. frame_ack -> PRE next cycle and frame_ready drops. frame_ack outside HOLD is ignored.
- run = 0 in any state: IDLE next cycle; frame_ready, wr_en and busy drop; an in-flight registered write is discarded. run = 0 has priority over frame_ack.
- hzoom change while busy (compared with the value latched on PRE entry): restart at PRE; the address is not reset.
- hzoom change in HOLD: no effect until the next PRE.
- ad_valid while not busy: ignored.
- busy is combinational from state.

Test Plan:
- ADDR_W=4, AUTO_TO=32, hzoom=0, rising, level=128, ramp 0,16,32,…: 8 PRE writes at addr 0..7. Sample 128 at addr 8 triggers; POST writes addr 9..15. frame_ready=1, start_addr=0, auto_trig=0.
- Constant ad_data=50, level=128: no edge; the 32nd ARMED sample force-triggers. auto_trig=1, frame_ready after 7 more writes, start_addr = trigger addr - 8 mod 16.
- hzoom=1, ad_valid every cycle: wr_en pulses every 2nd strobe, data = samples 0,2,4,…. With hzoom=2, data = samples 0,4,8,….
- Falling edge, level=100, input 120,110,100: trigger on the sample of 100. Rising with a sample exactly equal to the level from below: triggers. Sequence 130,140: no trigger.
- In HOLD, 1000 cycles with no ack: no writes and outputs stable. frame_ack pulse: frame_ready=0 next cycle, PRE, writes resume at the current wr_addr.
- run dropped in POST mid-write, and rst asserted in ARMED: next cycle wr_en=0, frame_ready=0, busy=0. Reset gives wr_addr=0 and state IDLE.

Source files
------------

// File: rtl/osc_capture_ctrl_if.sv
//------------------------------------------------------------------------------
// Module : osc_capture_ctrl_if
// Brief  : Control, sample, frame-RAM write and renderer handshake bundle
//          of the oscilloscope capture controller.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface osc_capture_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              run;
    logic [1:0]        hzoom;
    logic [7:0]        trig_level;
    logic              trig_edge;
    logic [7:0]        ad_data;
    logic              ad_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              frame_ready;
    logic              frame_ack;
    logic [ADDR_W-1:0] start_addr;
    logic              auto_trig;
    logic              busy;

    modport master (
        output run, hzoom, trig_level, trig_edge, ad_data, ad_valid, frame_ack,
        input  wr_en, wr_addr, wr_data, frame_ready, start_addr, auto_trig, busy
    );

    modport slave (
        input  run, hzoom, trig_level, trig_edge, ad_data, ad_valid, frame_ack,
        output wr_en, wr_addr, wr_data, frame_ready, start_addr, auto_trig, busy
    );
endinterface

`default_nettype wire

// File: rtl/osc_capture_ctrl.sv
//------------------------------------------------------------------------------
// Module : osc_capture_ctrl
// Brief  : Oscilloscope acquisition sequencer: decimation, pre-trigger fill,
//          edge/auto trigger, post-trigger fill and frame hold handshake.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module osc_capture_ctrl #(
    parameter int ADDR_W  = 10,
    parameter int AUTO_TO = 4096
) (
    input  wire logic         clk,
    input  wire logic         rst,
    osc_capture_ctrl_if.slave bus
);

    localparam int TO_W = $clog2(AUTO_TO + 1);
    localparam logic [ADDR_W-1:0] C_HALF    = ADDR_W'(2 ** (ADDR_W - 1));
    localparam logic [ADDR_W-1:0] C_HALF_M1 = ADDR_W'(2 ** (ADDR_W - 1) - 1);
    localparam logic [ADDR_W-1:0] C_HALF_M2 = ADDR_W'(2 ** (ADDR_W - 1) - 2);
    localparam logic [TO_W-1:0]   C_TO_LAST = TO_W'(AUTO_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        prev_q, prev_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [1:0]        dec_q, dec_d;
    logic [1:0]        hz_q, hz_d;
    logic [ADDR_W-1:0] start_q, start_d;
    logic              auto_q, auto_d;

    logic w_busy;
    logic w_dec_wrap;
    logic w_post_last;
    logic w_accept;
    logic w_rise;
    logic w_fall;
    logic w_edge_hit;
    logic w_timeout;
    logic w_hz_chg;
    logic w_enter_pre;

    assign w_busy      = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
    assign w_dec_wrap  = (hz_q == 2'd0) || ((hz_q == 2'd1) && (dec_q == 2'd1)) || (dec_q == 2'd3);
    // The final POST write must not leave a sample in flight into HOLD.
    assign w_post_last = (state_q == S_POST) && wr_en_q && (cnt_q == C_HALF_M2);
    assign w_accept    = w_busy && bus.ad_valid && (dec_q == 2'd0) && !w_post_last;
    assign w_rise      = (prev_q < bus.trig_level) && (wr_data_q >= bus.trig_level);
    assign w_fall      = (prev_q > bus.trig_level) && (wr_data_q <= bus.trig_level);
    assign w_edge_hit  = bus.trig_edge ? w_fall : w_rise;
    assign w_timeout   = (to_q == C_TO_LAST);
    assign w_hz_chg    = w_busy && (bus.hzoom != hz_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            dec_q     <= '0;
            hz_q      <= '0;
            start_q   <= '0;
            auto_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            dec_q     <= dec_d;
            hz_q      <= hz_d;
            start_q   <= start_d;
            auto_q    <= auto_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_data_d   = wr_data_q;
        prev_d      = prev_q;
        cnt_d       = cnt_q;
        to_d        = to_q;
        dec_d       = dec_q;
        hz_d        = hz_q;
        start_d     = start_q;
        auto_d      = auto_q;
        w_enter_pre = 1'b0;

        // Trigger and phase decisions are taken on the cycle the sample is written.
        if (wr_en_q) begin
            addr_d = addr_q + ADDR_W'(1);
            prev_d = wr_data_q;
        end
        if (w_busy && bus.ad_valid) begin
            dec_d = w_dec_wrap ? 2'd0 : dec_q + 2'd1;
        end
        if (w_accept) begin
            wr_en_d   = 1'b1;
            wr_data_d = bus.ad_data;
        end

        unique case (state_q)
            S_IDLE: begin
                addr_d      = '0;
                w_enter_pre = bus.run;
            end
            S_PRE: begin
                if (wr_en_q) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (cnt_q == C_HALF_M1) begin
                        state_d = S_ARMED;
                        to_d    = '0;
                    end
                end
            end
            S_ARMED: begin
                if (wr_en_q) begin
                    to_d = to_q + TO_W'(1);
                    if (w_edge_hit || w_timeout) begin
                        state_d = S_POST;
                        cnt_d   = '0;
                        start_d = addr_q - C_HALF;
                        auto_d  = !w_edge_hit;
                    end
                end
            end
            S_POST: begin
                if (wr_en_q) begin
                    cnt_d = cnt_q + ADDR_W'(1);
                    if (w_post_last) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                w_enter_pre = bus.frame_ack;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_hz_chg) begin
            w_enter_pre = 1'b1;
            wr_en_d     = 1'b0;
        end
        if (w_enter_pre) begin
            state_d = S_PRE;
            cnt_d   = '0;
            dec_d   = '0;
            hz_d    = bus.hzoom;
        end
        if (!bus.run) begin
            state_d = S_IDLE;
            addr_d  = '0;
            wr_en_d = 1'b0;
            dec_d   = '0;
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.frame_ready = (state_q == S_HOLD);
    assign bus.start_addr  = start_q;
    assign bus.auto_trig   = auto_q;
    assign bus.busy        = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_osc_capture_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_osc_capture_ctrl
// Brief  : Scoreboard bench for osc_capture_ctrl with a sample-level model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_osc_capture_ctrl;

    localparam int ADDR_W  = 4;
    localparam int AUTO_TO = 32;
    localparam int DEPTH   = 16;
    localparam int HALF    = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    osc_capture_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    osc_capture_ctrl #(.ADDR_W(ADDR_W), .AUTO_TO(AUTO_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct { int addr; int data; } wr_t;
    typedef struct { int start; int auto_t; } fr_t;
    wr_t exp_wr[$];
    fr_t exp_fr[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Frame model: one call per accepted sample, in sample order.
    int m_addr = 0, m_k = 0, m_n = 0, m_armed = 0, m_post = 0, m_prev = 0, m_div = 1;
    int m_hz = 0, m_fstart = 0, m_fauto = 0;
    bit m_active = 0, m_trig_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_start();
        m_active    = 1;
        m_k         = 0;
        m_n         = 0;
        m_armed     = 0;
        m_post      = 0;
        m_trig_seen = 0;
        m_hz        = int'(bus.hzoom);
        m_div       = (m_hz == 0) ? 1 : (m_hz == 1) ? 2 : 4;
    endfunction

    function automatic void m_write(input int s);
        bit hit;
        int lvl;
        lvl = int'(bus.trig_level);
        exp_wr.push_back(wr_t'{m_addr, s});
        if (m_n >= HALF) begin
            if (m_trig_seen) begin
                m_post++;
                if (m_post == HALF - 1) begin
                    m_active = 0;
                    exp_fr.push_back(fr_t'{m_fstart, m_fauto});
                end
            end else begin
                m_armed++;
                hit = bus.trig_edge ? (m_prev > lvl && s <= lvl) : (m_prev < lvl && s >= lvl);
                if (hit || m_armed == AUTO_TO) begin
                    m_trig_seen = 1;
                    m_fstart    = (m_addr - HALF + DEPTH) % DEPTH;
                    m_fauto     = hit ? 0 : 1;
                end
            end
        end
        m_prev = s;
        m_n++;
        m_addr = (m_addr + 1) % DEPTH;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int s);
        bus.ad_valid = 1'b1;
        bus.ad_data  = 8'(s);
        if (bus.run && !rst && m_active) begin
            if (m_k % m_div == 0) m_write(s & 255);
            m_k++;
        end
        step();
        bus.ad_valid = 1'b0;
    endtask

    function automatic int gen(input int mode, input int i);
        case (mode)
            0:       return (i * 16) & 255;
            1:       return 50;
            2:       return i & 255;
            default: return int'($urandom_range(255, 0));
        endcase
    endfunction

    task automatic feed_until_done(input int mode, input int maxgap);
        int i = 0;
        int budget = 0;
        while (m_active && budget < 3000) begin
            strobe(gen(mode, i));
            i++;
            budget++;
            repeat ($urandom_range(maxgap, 0)) begin
                step();
                budget++;
            end
        end
        if (m_active) begin
            n_tests++;
            n_fail++;
            $display("FAIL feed_timeout: frame still open after %0d cycles", budget);
        end
    endtask

    task automatic feed_list(input int vals[$]);
        foreach (vals[j]) strobe(vals[j]);
    endtask

    task automatic wait_frame();
        int t = 0;
        while (!bus.frame_ready && t < 60) begin
            step();
            t++;
        end
        check("frame_ready_wait", int'(bus.frame_ready), 1);
        step();
    endtask

    task automatic ack_frame();
        bus.frame_ack = 1'b1;
        step();
        bus.frame_ack = 1'b0;
        m_start();
        check("ack_frame_ready_low", int'(bus.frame_ready), 0);
        check("ack_busy", int'(bus.busy), 1);
    endtask

    // Monitor: pops expected writes and frames as the DUT presents them.
    initial begin : monitor
        logic prev_fr;
        wr_t  w;
        fr_t  f;
        prev_fr = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.wr_en === 1'b1) begin
                if (exp_wr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %0d at %0t", bus.wr_addr, bus.wr_data, $time);
                end else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", int'(bus.wr_addr), w.addr);
                    check("wr_data", int'(bus.wr_data), w.data);
                end
            end
            if (bus.frame_ready === 1'b1 && prev_fr !== 1'b1) begin
                if (exp_fr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: start %0d at %0t", bus.start_addr, $time);
                end else begin
                    f = exp_fr.pop_front();
                    check("frame_start_addr", int'(bus.start_addr), f.start);
                    check("frame_auto_trig", int'(bus.auto_trig), f.auto_t);
                end
            end
            prev_fr = bus.frame_ready;
        end
    end

    initial begin : watchdog
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int q[$];
        int r, nh, budget, hold_wr;

        rst            = 1'b1;
        bus.run        = 1'b0;
        bus.hzoom      = 2'd0;
        bus.trig_level = 8'd128;
        bus.trig_edge  = 1'b0;
        bus.ad_data    = 8'd0;
        bus.ad_valid   = 1'b0;
        bus.frame_ack  = 1'b0;
        repeat (3) step();
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_frame_ready", int'(bus.frame_ready), 0);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_wr_addr", int'(bus.wr_addr), 0);
        check("rst_wr_data", int'(bus.wr_data), 0);
        check("rst_start_addr", int'(bus.start_addr), 0);
        check("rst_auto_trig", int'(bus.auto_trig), 0);
        rst = 1'b0;
        step();

        // Ramp: sample 128 at address 8 is the rising trigger.
        bus.run = 1'b1;
        m_addr  = 0;
        m_start();
        step();
        check("run_busy", int'(bus.busy), 1);
        feed_until_done(0, 0);
        wait_frame();
        check("ramp_start_addr", int'(bus.start_addr), 0);
        check("ramp_auto_trig", int'(bus.auto_trig), 0);

        // HOLD: strobes ignored, outputs stable.
        hold_wr = 0;
        for (int c = 0; c < 1000; c++) begin
            bus.ad_valid = 1'($urandom_range(1, 0));
            bus.ad_data  = 8'($urandom_range(255, 0));
            step();
            hold_wr += int'(bus.wr_en);
        end
        bus.ad_valid = 1'b0;
        check("hold_no_writes", hold_wr, 0);
        check("hold_frame_ready", int'(bus.frame_ready), 1);
        check("hold_start_addr", int'(bus.start_addr), 0);
        check("hold_wr_addr", int'(bus.wr_addr), 0);

        // Constant input never crosses the level: auto trigger at addr 7.
        ack_frame();
        feed_until_done(1, 1);
        wait_frame();
        check("auto_auto_trig", int'(bus.auto_trig), 1);
        check("auto_start_addr", int'(bus.start_addr), 15);

        // Falling edge at level 100 fires on the sample equal to 100.
        bus.trig_edge  = 1'b1;
        bus.trig_level = 8'd100;
        ack_frame();
        q = {120, 120, 120, 120, 120, 120, 120, 120, 120, 110, 100,
             90, 80, 70, 60, 50, 40, 30};
        feed_list(q);
        wait_frame();
        check("fall_auto_trig", int'(bus.auto_trig), 0);
        check("fall_start_addr", int'(bus.start_addr), 1);

        // Rising: 130,140 stay above the level; 100 then 128 triggers.
        bus.trig_edge  = 1'b0;
        bus.trig_level = 8'd128;
        ack_frame();
        q = {130, 130, 130, 130, 130, 130, 130, 130, 130, 140, 100, 128,
             1, 2, 3, 4, 5, 6, 7};
        feed_list(q);
        wait_frame();
        check("rise_auto_trig", int'(bus.auto_trig), 0);
        check("rise_start_addr", int'(bus.start_addr), 4);

        // Decimation /2 and /4 with a strobe every cycle.
        bus.trig_level = 8'd255;
        bus.hzoom      = 2'd1;
        ack_frame();
        feed_until_done(2, 0);
        wait_frame();
        bus.hzoom = 2'd2;
        ack_frame();
        feed_until_done(2, 0);
        wait_frame();

        // Randomised frames with mid-frame hzoom changes.
        for (int f = 0; f < 8; f++) begin
            bus.hzoom      = 2'($urandom_range(3, 0));
            bus.trig_level = 8'($urandom_range(255, 0));
            bus.trig_edge  = 1'($urandom_range(1, 0));
            ack_frame();
            budget = 0;
            while (m_active && budget < 4000) begin
                r = int'($urandom_range(99, 0));
                if (r < 2) begin
                    nh        = int'($urandom_range(3, 0));
                    bus.hzoom = 2'(nh);
                    step();
                    if (nh != m_hz) m_start();
                end else if (r < 60) begin
                    strobe(int'($urandom_range(255, 0)));
                end else begin
                    step();
                end
                budget++;
            end
            if (m_active) begin
                n_tests++;
                n_fail++;
                $display("FAIL random_frame_timeout: frame %0d open after %0d cycles", f, budget);
            end
            wait_frame();
        end

        // run dropped during POST with a sample accepted on the same edge.
        bus.hzoom      = 2'd0;
        bus.trig_level = 8'd128;
        bus.trig_edge  = 1'b0;
        ack_frame();
        budget = 0;
        while (!(m_trig_seen && m_post >= 3) && budget < 100) begin
            strobe(gen(0, budget));
            budget++;
        end
        bus.run      = 1'b0;
        bus.ad_valid = 1'b1;
        bus.ad_data  = 8'd200;
        m_active     = 0;
        m_addr       = 0;
        step();
        bus.ad_valid = 1'b0;
        check("rundrop_wr_en", int'(bus.wr_en), 0);
        check("rundrop_frame_ready", int'(bus.frame_ready), 0);
        check("rundrop_busy", int'(bus.busy), 0);
        check("rundrop_wr_addr", int'(bus.wr_addr), 0);

        // Reset asserted while ARMED.
        bus.run = 1'b1;
        m_start();
        step();
        for (int j = 0; j < 10; j++) strobe(50);
        check("armed_busy", int'(bus.busy), 1);
        rst          = 1'b1;
        bus.ad_valid = 1'b1;
        bus.ad_data  = 8'd77;
        m_active     = 0;
        m_addr       = 0;
        step();
        bus.ad_valid = 1'b0;
        check("rstarmed_wr_en", int'(bus.wr_en), 0);
        check("rstarmed_frame_ready", int'(bus.frame_ready), 0);
        check("rstarmed_busy", int'(bus.busy), 0);
        check("rstarmed_wr_addr", int'(bus.wr_addr), 0);
        check("rstarmed_start_addr", int'(bus.start_addr), 0);
        bus.run = 1'b0;
        rst     = 1'b0;
        repeat (3) step();
        check("idle_busy", int'(bus.busy), 0);
        check("idle_wr_addr", int'(bus.wr_addr), 0);

        check("writes_outstanding", exp_wr.size(), 0);
        check("frames_outstanding", exp_fr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
